// File: rtl/riscv_shared_dsp_req_pkg.sv
// Shared types and constants for the shared-DSP request initiator.
// Operator encodings match ALU_OP_WIDTH-wide riscv_defines values.
package riscv_shared_dsp_req_pkg;

   localparam int unsigned ALU_OP_WIDTH = 7;

   localparam logic [1:0] VEC_MODE32 = 2'b00;
   localparam logic [1:0] VEC_MODE16 = 2'b10;
   localparam logic [1:0] VEC_MODE8  = 2'b11;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'b0011000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MIN = 7'b0010000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } shared_dsp_state_e;

   typedef struct packed {
      logic [ALU_OP_WIDTH-1:0] op;
      logic [31:0]             a;
      logic [31:0]             b;
      logic [31:0]             c;
      logic [1:0]              vec_mode;
   } shared_dsp_req_t;

endpackage

// File: rtl/riscv_shared_dsp_req_if.sv
// Request/response channel between a core and the cluster-shared DSP.
// master = initiating core, slave = shared DSP responder.
interface riscv_shared_dsp_req_if #(
   parameter int unsigned OP_WIDTH = 7
);
   logic                req;
   logic                gnt;
   logic [OP_WIDTH-1:0] op;
   logic [31:0]         op_a;
   logic [31:0]         op_b;
   logic [31:0]         op_c;
   logic [1:0]          vec_mode;
   logic                rvalid;
   logic [31:0]         rdata;
   logic                rflag;

   modport master (
      output req, op, op_a, op_b, op_c, vec_mode,
      input  gnt, rvalid, rdata, rflag
   );

   modport slave (
      input  req, op, op_a, op_b, op_c, vec_mode,
      output gnt, rvalid, rdata, rflag
   );
endinterface

// File: rtl/riscv_shared_dsp_watchdog.sv
// Response watchdog: counts cycles while a request is outstanding and
// flags expiry once TIMEOUT_CYCLES-1 is reached. Saturates, never wraps.
module riscv_shared_dsp_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic active_i,
   output logic expired_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (active_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = active_i && (cnt_q == LIMIT);

endmodule

// File: rtl/riscv_shared_dsp_req.sv
// EX-stage initiator for the cluster-shared DSP: one outstanding request,
// result held until EX consumes it. Watchdog under RISCV_SHARED_DSP_TIMEOUT_EN.
module riscv_shared_dsp_req
   import riscv_shared_dsp_req_pkg::*;
#(
   parameter int unsigned OP_WIDTH       = ALU_OP_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,

   input  logic                          enable_i,
   input  logic [OP_WIDTH-1:0]           operator_i,
   input  logic [31:0]                   operand_a_i,
   input  logic [31:0]                   operand_b_i,
   input  logic [31:0]                   operand_c_i,
   input  logic [1:0]                    vector_mode_i,

   output logic [31:0]                   result_o,
   output logic                          comparison_result_o,
   output logic                          ready_o,
   input  logic                          ex_ready_i,

   riscv_shared_dsp_req_if.master        dsp,

   output logic                          timeout_err_o
);

   shared_dsp_state_e state_q, state_d;
   shared_dsp_req_t   payload_q, payload_d, new_req;
   logic              req_q, req_d;
   logic [31:0]       result_q, result_d;
   logic              flag_q, flag_d;
   logic              tmo_q, tmo_d;
   logic              expired;

   always_comb begin
      new_req.op       = ALU_OP_WIDTH'(operator_i);
      new_req.a        = operand_a_i;
      new_req.b        = operand_b_i;
      new_req.c        = operand_c_i;
      new_req.vec_mode = vector_mode_i;
   end

`ifdef RISCV_SHARED_DSP_TIMEOUT_EN
   logic wd_clear;
   logic wd_active;

   assign wd_clear  = (state_d == REQ) && (state_q != REQ);
   assign wd_active = (state_q == REQ) || (state_q == WAIT_RSP);

   riscv_shared_dsp_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear),
      .active_i  (wd_active),
      .expired_o (expired)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign expired            = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      payload_d = payload_q;
      req_d     = req_q;
      result_d  = result_q;
      flag_d    = flag_q;
      tmo_d     = tmo_q;

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               payload_d = new_req;
               req_d     = 1'b1;
               state_d   = REQ;
            end
         end
         // A grant arriving with the expiry cycle still counts as timed out:
         // no response can be accepted while in REQ.
         REQ: begin
            if (expired) begin
               req_d    = 1'b0;
               result_d = '0;
               flag_d   = 1'b0;
               tmo_d    = 1'b1;
               state_d  = DONE;
            end else if (dsp.gnt) begin
               req_d   = 1'b0;
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (dsp.rvalid) begin
               result_d = dsp.rdata;
               flag_d   = dsp.rflag;
               state_d  = DONE;
            end else if (expired) begin
               result_d = '0;
               flag_d   = 1'b0;
               tmo_d    = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (ex_ready_i) begin
               tmo_d = 1'b0;
               if (enable_i) begin
                  payload_d = new_req;
                  req_d     = 1'b1;
                  state_d   = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         payload_q <= '0;
         req_q     <= 1'b0;
         result_q  <= '0;
         flag_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         payload_q <= payload_d;
         req_q     <= req_d;
         result_q  <= result_d;
         flag_q    <= flag_d;
         tmo_q     <= tmo_d;
      end
   end

   assign ready_o             = ((state_q == IDLE) && !enable_i) || (state_q == DONE);
   assign result_o            = result_q;
   assign comparison_result_o = flag_q;
   assign timeout_err_o       = tmo_q;

   assign dsp.req      = req_q;
   assign dsp.op       = OP_WIDTH'(payload_q.op);
   assign dsp.op_a     = payload_q.a;
   assign dsp.op_b     = payload_q.b;
   assign dsp.op_c     = payload_q.c;
   assign dsp.vec_mode = payload_q.vec_mode;

endmodule

// File: tb/tb_riscv_shared_dsp_req.sv
// Self-checking bench for riscv_shared_dsp_req; acts as the shared-DSP responder.
module tb_riscv_shared_dsp_req;
   import riscv_shared_dsp_req_pkg::*;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0;
   logic [6:0]  operator_i = '0;
   logic [31:0] operand_a_i = '0, operand_b_i = '0, operand_c_i = '0;
   logic [1:0]  vector_mode_i = '0;
   logic [31:0] result_o;
   logic        comparison_result_o, ready_o, timeout_err_o;
   logic        ex_ready_i = 1'b1;

   int errors = 0;
   int checks = 0;

   riscv_shared_dsp_req_if #(.OP_WIDTH(7)) dsp_if ();

   riscv_shared_dsp_req #(
      .OP_WIDTH       (7),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .enable_i            (enable_i),
      .operator_i          (operator_i),
      .operand_a_i         (operand_a_i),
      .operand_b_i         (operand_b_i),
      .operand_c_i         (operand_c_i),
      .vector_mode_i       (vector_mode_i),
      .result_o            (result_o),
      .comparison_result_o (comparison_result_o),
      .ready_o             (ready_o),
      .ex_ready_i          (ex_ready_i),
      .dsp                 (dsp_if),
      .timeout_err_o       (timeout_err_o)
   );

   always #5 clk = ~clk;

   // Model state: the last response the initiator was obliged to accept.
   logic [31:0] exp_result = '0;
   logic        exp_flag   = 1'b0;

   function automatic shared_dsp_req_t rand_req();
      shared_dsp_req_t r;
      r.op       = 7'($urandom);
      r.a        = $urandom;
      r.b        = $urandom;
      r.c        = $urandom;
      r.vec_mode = 2'($urandom);
      return r;
   endfunction

   function automatic shared_dsp_req_t observed_payload();
      shared_dsp_req_t r;
      r.op       = dsp_if.op;
      r.a        = dsp_if.op_a;
      r.b        = dsp_if.op_b;
      r.c        = dsp_if.op_c;
      r.vec_mode = dsp_if.vec_mode;
      return r;
   endfunction

   task automatic drive_op(input shared_dsp_req_t r);
      operator_i    = r.op;
      operand_a_i   = r.a;
      operand_b_i   = r.b;
      operand_c_i   = r.c;
      vector_mode_i = r.vec_mode;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable_i      = 1'b0;
      ex_ready_i    = 1'b1;
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b0;
      dsp_if.rdata  = '0;
      dsp_if.rflag  = 1'b0;
   endtask

   // Quick op with immediate grant and response; leaves the DUT in IDLE.
   task automatic do_op(input logic [31:0] data, input logic flag);
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = data;
      dsp_if.rflag  = flag;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = data;
      exp_flag      = flag;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
      checks++;
      if (dsp_if.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dsp_if.req); end
      checks++;
      if ({result_o, comparison_result_o, timeout_err_o} !== 34'd0)
         begin errors++; $display("FAIL reset_result: got %h/%b/%b expected 0/0/0", result_o, comparison_result_o, timeout_err_o); end
      checks++;
      if (observed_payload() !== '0)
         begin errors++; $display("FAIL reset_payload: got %h expected 0", observed_payload()); end
      rst = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready_o); end
      exp_result = '0;
      exp_flag   = 1'b0;
   endtask

   task automatic test_single_op();
      shared_dsp_req_t r;
      r = '{op: ALU_MIN, a: 32'hFFFF0001, b: 32'h00000002, c: 32'h0, vec_mode: VEC_MODE16};
      drive_op(r);
      enable_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL single_c0_ready: got %b expected 0", ready_o); end
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      #1;
      checks++;
      if (dsp_if.req !== 1'b1 || ready_o !== 1'b0)
         begin errors++; $display("FAIL single_c1_req: got req=%b ready=%b expected req=1 ready=0", dsp_if.req, ready_o); end
      checks++;
      if (observed_payload() !== r)
         begin errors++; $display("FAIL single_c1_payload: got %h expected %h", observed_payload(), r); end
      tick();
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'hFFFF0001;
      dsp_if.rflag  = 1'b1;
      #1;
      checks++;
      if (dsp_if.req !== 1'b0 || ready_o !== 1'b0)
         begin errors++; $display("FAIL single_c2: got req=%b ready=%b expected req=0 ready=0", dsp_if.req, ready_o); end
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'hFFFF0001;
      exp_flag      = 1'b1;
      checks++;
      if (ready_o !== 1'b1 || result_o !== exp_result || comparison_result_o !== exp_flag)
         begin errors++; $display("FAIL single_c3: got ready=%b result=%h flag=%b expected 1/%h/%b", ready_o, result_o, comparison_result_o, exp_result, exp_flag); end
      tick();
   endtask

   task automatic test_backpressure();
      shared_dsp_req_t r;
      r = rand_req();
      drive_op(r);
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_op(rand_req());
         #1;
         checks++;
         if (dsp_if.req !== 1'b1 || observed_payload() !== r)
            begin errors++; $display("FAIL bp_hold%0d: got req=%b payload=%h expected 1/%h", k, dsp_if.req, observed_payload(), r); end
         tick();
      end
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt = 1'b0;
      checks++;
      if (dsp_if.req !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b expected 0", dsp_if.req); end
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h0000_0042;
      dsp_if.rflag  = 1'b0;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'h0000_0042;
      exp_flag      = 1'b0;
      checks++;
      if (result_o !== exp_result) begin errors++; $display("FAIL bp_result: got %h expected %h", result_o, exp_result); end
      tick();
   endtask

   task automatic test_ex_stall();
      shared_dsp_req_t nr;
      do_op(32'hCAFE_0001, 1'b1);
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h1357_9BDF;
      dsp_if.rflag  = 1'b1;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'h1357_9BDF;
      exp_flag      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ex_ready_i = 1'b0;
         enable_i   = k[0];
         drive_op(rand_req());
         #1;
         checks++;
         if (result_o !== exp_result || comparison_result_o !== exp_flag || dsp_if.req !== 1'b0 || ready_o !== 1'b1)
            begin errors++; $display("FAIL stall%0d: got result=%h flag=%b req=%b ready=%b expected %h/%b/0/1", k, result_o, comparison_result_o, dsp_if.req, ready_o, exp_result, exp_flag); end
         tick();
      end
      nr = rand_req();
      drive_op(nr);
      ex_ready_i = 1'b1;
      enable_i   = 1'b1;
      tick();
      enable_i = 1'b0;
      checks++;
      if (dsp_if.req !== 1'b1 || observed_payload() !== nr)
         begin errors++; $display("FAIL b2b_issue: got req=%b payload=%h expected 1/%h", dsp_if.req, observed_payload(), nr); end
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h2468_ACE0;
      dsp_if.rflag  = 1'b0;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'h2468_ACE0;
      exp_flag      = 1'b0;
      checks++;
      if (result_o !== exp_result || ready_o !== 1'b1)
         begin errors++; $display("FAIL b2b_result: got %h ready=%b expected %h/1", result_o, ready_o, exp_result); end
      tick();
   endtask

   task automatic test_stray_response();
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'hDEADBEEF;
      dsp_if.rflag  = ~exp_flag;
      tick();
      checks++;
      if (result_o !== exp_result || comparison_result_o !== exp_flag || ready_o !== 1'b1 || dsp_if.req !== 1'b0)
         begin errors++; $display("FAIL stray_idle: got %h/%b ready=%b req=%b expected %h/%b/1/0", result_o, comparison_result_o, ready_o, dsp_if.req, exp_result, exp_flag); end
      dsp_if.rvalid = 1'b0;
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i      = 1'b0;
      dsp_if.rvalid = 1'b1;
      tick();
      checks++;
      if (result_o !== exp_result || ready_o !== 1'b0 || dsp_if.req !== 1'b1)
         begin errors++; $display("FAIL stray_req: got %h ready=%b req=%b expected %h/0/1", result_o, ready_o, dsp_if.req, exp_result); end
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt    = 1'b0;
      dsp_if.rvalid = 1'b0;
      tick();
      checks++;
      if (result_o !== exp_result || ready_o !== 1'b0)
         begin errors++; $display("FAIL stray_with_gnt: got %h ready=%b expected %h/0", result_o, ready_o, exp_result); end
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h1234_5678;
      dsp_if.rflag  = 1'b1;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'h1234_5678;
      exp_flag      = 1'b1;
      checks++;
      if (result_o !== exp_result || comparison_result_o !== exp_flag || ready_o !== 1'b1)
         begin errors++; $display("FAIL stray_real_rsp: got %h/%b ready=%b expected %h/%b/1", result_o, comparison_result_o, ready_o, exp_result, exp_flag); end
      tick();
   endtask

   task automatic test_random();
      shared_dsp_req_t cur;
      bit pending = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!pending) begin
            cur = rand_req();
            drive_op(cur);
            enable_i = 1'b1;
            tick();
            enable_i = 1'b0;
         end
         pending = 1'b0;
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            drive_op(rand_req());
            dsp_if.rvalid = $urandom_range(0, 1);
            dsp_if.rdata  = $urandom;
            #1;
            checks++;
            if (dsp_if.req !== 1'b1 || observed_payload() !== cur || ready_o !== 1'b0)
               begin errors++; $display("FAIL rnd%0d_req: got req=%b payload=%h ready=%b expected 1/%h/0", n, dsp_if.req, observed_payload(), ready_o, cur); end
            tick();
         end
         dsp_if.rvalid = 1'b0;
         dsp_if.gnt    = 1'b1;
         tick();
         dsp_if.gnt = 1'b0;
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            tick();
         end
         checks++;
         if (dsp_if.req !== 1'b0 || ready_o !== 1'b0)
            begin errors++; $display("FAIL rnd%0d_wait: got req=%b ready=%b expected 0/0", n, dsp_if.req, ready_o); end
         dsp_if.rvalid = 1'b1;
         dsp_if.rdata  = $urandom;
         dsp_if.rflag  = $urandom_range(0, 1);
         exp_result    = dsp_if.rdata;
         exp_flag      = dsp_if.rflag;
         tick();
         dsp_if.rvalid = 1'b0;
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            ex_ready_i = 1'b0;
            enable_i   = $urandom_range(0, 1);
            tick();
         end
         checks++;
         if (result_o !== exp_result || comparison_result_o !== exp_flag || ready_o !== 1'b1 || dsp_if.req !== 1'b0)
            begin errors++; $display("FAIL rnd%0d_done: got %h/%b ready=%b req=%b expected %h/%b/1/0", n, result_o, comparison_result_o, ready_o, dsp_if.req, exp_result, exp_flag); end
         ex_ready_i = 1'b1;
         if (n < 39 && $urandom_range(0, 1) == 1) begin
            cur = rand_req();
            drive_op(cur);
            enable_i = 1'b1;
            pending  = 1'b1;
         end else begin
            enable_i = 1'b0;
         end
         tick();
         enable_i = 1'b0;
      end
   endtask

`ifdef RISCV_SHARED_DSP_TIMEOUT_EN
   task automatic test_timeout();
      do_op(32'hA5A5_A5A5, 1'b1);
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         checks++;
         if (ready_o !== 1'b0 || timeout_err_o !== 1'b0)
            begin errors++; $display("FAIL tmo_early_c%0d: got ready=%b err=%b expected 0/0", k, ready_o, timeout_err_o); end
         tick();
      end
      ex_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (timeout_err_o !== 1'b1 || ready_o !== 1'b1 || result_o !== 32'h0 || comparison_result_o !== 1'b0 || dsp_if.req !== 1'b0)
            begin errors++; $display("FAIL tmo_fire%0d: got err=%b ready=%b result=%h flag=%b req=%b expected 1/1/0/0/0", k, timeout_err_o, ready_o, result_o, comparison_result_o, dsp_if.req); end
         tick();
      end
      ex_ready_i = 1'b1;
      tick();
      checks++;
      if (timeout_err_o !== 1'b0 || ready_o !== 1'b1)
         begin errors++; $display("FAIL tmo_clear: got err=%b ready=%b expected 0/1", timeout_err_o, ready_o); end

      do_op(32'h5A5A_5A5A, 1'b0);
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         checks++;
         if (dsp_if.req !== 1'b1 || timeout_err_o !== 1'b0)
            begin errors++; $display("FAIL tmo_req_c%0d: got req=%b err=%b expected 1/0", k, dsp_if.req, timeout_err_o); end
         tick();
      end
      checks++;
      if (dsp_if.req !== 1'b0 || timeout_err_o !== 1'b1 || result_o !== 32'h0)
         begin errors++; $display("FAIL tmo_req_fire: got req=%b err=%b result=%h expected 0/1/0", dsp_if.req, timeout_err_o, result_o); end
      tick();

      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt = 1'b0;
      repeat (6) tick();
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h0BAD_F00D;
      dsp_if.rflag  = 1'b1;
      tick();
      dsp_if.rvalid = 1'b0;
      checks++;
      if (timeout_err_o !== 1'b0 || result_o !== 32'h0BAD_F00D || ready_o !== 1'b1)
         begin errors++; $display("FAIL tmo_rsp_wins: got err=%b result=%h ready=%b expected 0/0badf00d/1", timeout_err_o, result_o, ready_o); end
      exp_result = 32'h0BAD_F00D;
      exp_flag   = 1'b1;
      tick();
   endtask
`else
   task automatic test_timeout();
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt = 1'b0;
      repeat (3 * TMO) tick();
      checks++;
      if (timeout_err_o !== 1'b0 || ready_o !== 1'b0 || result_o !== exp_result)
         begin errors++; $display("FAIL no_tmo: got err=%b ready=%b result=%h expected 0/0/%h", timeout_err_o, ready_o, result_o, exp_result); end
      dsp_if.rvalid = 1'b1;
      dsp_if.rdata  = 32'h7777_1111;
      dsp_if.rflag  = 1'b0;
      tick();
      dsp_if.rvalid = 1'b0;
      exp_result    = 32'h7777_1111;
      exp_flag      = 1'b0;
      checks++;
      if (result_o !== exp_result || ready_o !== 1'b1)
         begin errors++; $display("FAIL no_tmo_rsp: got %h ready=%b expected %h/1", result_o, ready_o, exp_result); end
      tick();
   endtask
`endif

   task automatic test_midop_reset();
      do_op(32'h9999_0001, 1'b1);
      drive_op(rand_req());
      enable_i = 1'b1;
      tick();
      enable_i   = 1'b0;
      dsp_if.gnt = 1'b1;
      tick();
      dsp_if.gnt = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (dsp_if.req !== 1'b0 || result_o !== 32'h0 || ready_o !== 1'b1 || observed_payload() !== '0)
         begin errors++; $display("FAIL midop_reset: got req=%b result=%h ready=%b payload=%h expected 0/0/1/0", dsp_if.req, result_o, ready_o, observed_payload()); end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b1 || dsp_if.req !== 1'b0)
         begin errors++; $display("FAIL after_reset: got ready=%b req=%b expected 1/0", ready_o, dsp_if.req); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global time limit");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_single_op();
      test_backpressure();
      test_ex_stall();
      test_stray_response();
      test_random();
      test_timeout();
      test_midop_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
